key_event_detector: RTL and testbench
=====================================

Name: key_event_detector

Overview:
- Front-end stage that sits directly upstream of electric_clock's mode/set logic and feeds it.
- Takes the four raw active-low push-button inputs, synchronises and debounces each one, and classifies every press.
- Emits one-cycle event pulses per key: press, short press, long press and auto-repeat, plus a level-debounced held state.
- electric_clock consumes the pulses instead of the raw Key bus.

Parameters:
- MCNT_DB, 1_000_000, debounce window in Clk cycles (20 ms at 50 MHz); legal range >= 2.
- MCNT_LONG, 50_000_000, hold time in cycles after debounced press before Key_long fires (1 s); must be > MCNT_DB.
- MCNT_RPT, 10_000_000, auto-repeat period in cycles after Key_long (200 ms); legal range >= 2.
- RPT_EN, 1, 1 = Key_repeat enabled; 0 = Key_repeat held 0.

Ports:
- Clk  in  1  system clock, 50 MHz; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Key  in  4  raw buttons, active-low, asynchronous to Clk, may bounce.
- Key_state  out  4  debounced level, 1 = key held.
- Key_press  out  4  1-cycle pulse on debounced press.
- Key_short  out  4  1-cycle pulse on debounced release when Key_long did not fire for that press.
- Key_long  out  4  1-cycle pulse when hold time reaches MCNT_LONG.
- Key_repeat  out  4  1-cycle pulse every MCNT_RPT cycles while held after Key_long.

Behaviour:
- Synchroniser: per key, 2-FF; both FFs reset to 1. k_s is the second FF output.
- Per-key FSM: the four keys are fully independent. Any combination may be active in the same cycle with no priority.
- FSM states and transitions:
  - IDLE: on k_s=0 -> FILT_DN, db_cnt<=0.
  - FILT_DN: k_s=1 -> IDLE (bounce rejected, no output). Otherwise db_cnt++. When db_cnt==MCNT_DB-1 and k_s=0 -> DOWN, Key_press=1 for that cycle, Key_state<=1, hold_cnt<=0, long_flag<=0.
  - DOWN: hold_cnt++. When hold_cnt==MCNT_LONG-1 -> LONG, Key_long=1 for that cycle, long_flag<=1, rpt_cnt<=0. On k_s=1 -> FILT_UP, db_cnt<=0, hold_cnt frozen.
  - LONG: rpt_cnt++. When rpt_cnt==MCNT_RPT-1: Key_repeat=1 if RPT_EN, rpt_cnt<=0. On k_s=1 -> FILT_UP, db_cnt<=0.
  - FILT_UP: k_s=0 -> return to DOWN if long_flag=0, else LONG; counters resume, no pulse. Otherwise db_cnt++. When db_cnt==MCNT_DB-1 and k_s=1 -> IDLE, Key_state<=0, Key_short=1 iff long_flag=0.
- Latency (clean edge): Key_press rises exactly MCNT_DB+3 Clk edges after the first edge that samples Key low (2 sync + 1 FSM entry + MCNT_DB count). Release pulses use the same latency.
- Key_long: rises exactly MCNT_LONG cycles after Key_press.
- Key_repeat: first pulse exactly MCNT_RPT cycles after Key_long, then periodic.
- Pulse exclusivity: all event outputs are registered. Key_short and Key_long never both fire for the same press.
- Counter widths: $clog2 of the respective parameter. Counters never wrap, because the FSM leaves or clears before overflow.
- Reset (any cycle, including mid-press): all FSMs -> IDLE, all counters 0, all outputs 0, sync FFs 1. No pulse is emitted on reset release. A key still held after reset needs a full debounce and then produces Key_press.
- Bounce shorter than MCNT_DB cycles produces no event and no Key_state change.

Decomposition:
- Shared package key_pkg: the FSM state enum (IDLE, FILT_DN, DOWN, LONG, FILT_UP) and the key-index constants KEY_MODE=3, KEY_UP=2, KEY_DN=1, KEY_OK=0, also used by electric_clock.
- Sub-module key_filter: one key's synchroniser, FSM and counters, 1-bit outputs.
- key_event_detector: instantiates key_filter four times via generate and concatenates the outputs.

Test Plan:
All scenarios use MCNT_DB=4, MCNT_LONG=20, MCNT_RPT=5, 20 ns Clk.
1. Reset=1 for 5 cycles with Key=4'b0000 -> all outputs 0. After release, Key_press=4'b1111 exactly 7 cycles later, Key_state=4'b1111.
2. Key[3] low 12 cycles, then high -> one Key_press[3] pulse at +7. Key_short[3] pulse 7 cycles after the rise. No Key_long. Other bits stay 0.
3. Key[2] glitches low 3 cycles, high 2, low 2, high -> no pulses, Key_state[2]=0 throughout.
4. Key[2] low 60 cycles, RPT_EN=1 -> Key_press, then Key_long 20 cycles later, Key_repeat every 5 cycles after that, no Key_short on release. With RPT_EN=0, Key_repeat stays 0.
5. Key[1] held past Key_long with a 2-cycle high glitch mid-hold -> stays in LONG, repeats continue on schedule, no extra Key_press.
6. Key[0] press and Key[3] release in the same cycle -> Key_press[0] and Key_short[3] pulse in the same cycle, independently. Reset asserted mid-DOWN -> outputs 0 the next cycle, no Key_short.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the push-button front end: per-key FSM states and
// the key-index map used by the downstream clock mode/set logic.
package key_pkg;

  // Per-key debounce/classification states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILT_DN = 3'd1,
    DOWN    = 3'd2,
    LONG    = 3'd3,
    FILT_UP = 3'd4
  } key_state_e;

  localparam int NUM_KEYS = 4;

  // Bit positions of each button on the Key bus.
  localparam int KEY_MODE = 3;
  localparam int KEY_UP   = 2;
  localparam int KEY_DN   = 1;
  localparam int KEY_OK   = 0;

endpackage

// File: rtl/key_filter.sv
// One push button: 2-FF synchroniser, debounce FSM and press classifier.
// The raw input is active-low; every output is a registered, active-high
// level (key_state) or single-cycle pulse.
module key_filter
  import key_pkg::*;
#(
  parameter int MCNT_DB   = 1_000_000,
  parameter int MCNT_LONG = 50_000_000,
  parameter int MCNT_RPT  = 10_000_000,
  parameter bit RPT_EN    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic key_state,
  output logic key_press,
  output logic key_short,
  output logic key_long,
  output logic key_repeat
);

  localparam int DB_W   = $clog2(MCNT_DB);
  localparam int HOLD_W = $clog2(MCNT_LONG);
  localparam int RPT_W  = $clog2(MCNT_RPT);

  // Terminal counts; each counter is compared against its last value and
  // never counts past it, so it cannot wrap.
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(MCNT_DB - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MCNT_LONG - 1);
  localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(MCNT_RPT - 1);

  logic [1:0]        sync_q, sync_d;
  logic              k_s;
  key_state_e        state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [RPT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
  logic              long_flag_q, long_flag_d;
  logic              key_state_q, key_state_d;
  logic              press_q, press_d;
  logic              short_q, short_d;
  logic              long_q, long_d;
  logic              repeat_q, repeat_d;

  // Second synchroniser stage is the only view of the button the FSM uses.
  assign k_s = sync_q[1];

  // Shift the raw button level through the two synchroniser stages.
  always_comb begin
    sync_d = {sync_q[0], key_n};
  end

  // Next-state, counter and pulse logic for the debounce/classify FSM.
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    rpt_cnt_d   = rpt_cnt_q;
    long_flag_d = long_flag_q;
    key_state_d = key_state_q;
    press_d     = 1'b0;
    short_d     = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!k_s) begin
          state_d  = FILT_DN;
          db_cnt_d = {DB_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end

      FILT_DN: begin
        if (k_s) begin
          // Press did not stay low for the whole window: treat as bounce.
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = DOWN;
          press_d     = 1'b1;
          key_state_d = 1'b1;
          hold_cnt_d  = {HOLD_W{1'b0}};
          long_flag_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      DOWN: begin
        // A release candidate takes precedence; the hold count freezes
        // while the release is being filtered.
        if (k_s) begin
          state_d  = FILT_UP;
          db_cnt_d = {DB_W{1'b0}};
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d     = LONG;
          long_d      = 1'b1;
          long_flag_d = 1'b1;
          rpt_cnt_d   = {RPT_W{1'b0}};
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      LONG: begin
        if (k_s) begin
          state_d  = FILT_UP;
          db_cnt_d = {DB_W{1'b0}};
        end else if (rpt_cnt_q == RPT_LAST) begin
          repeat_d  = RPT_EN;
          rpt_cnt_d = {RPT_W{1'b0}};
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end

      FILT_UP: begin
        if (!k_s) begin
          // Release glitch: resume the hold phase we came from, silently.
          if (long_flag_q) begin
            state_d = LONG;
          end else begin
            state_d = DOWN;
          end
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = IDLE;
          key_state_d = 1'b0;
          short_d     = ~long_flag_q;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, synchroniser and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      db_cnt_q    <= {DB_W{1'b0}};
      hold_cnt_q  <= {HOLD_W{1'b0}};
      rpt_cnt_q   <= {RPT_W{1'b0}};
      long_flag_q <= 1'b0;
      key_state_q <= 1'b0;
      press_q     <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      rpt_cnt_q   <= rpt_cnt_d;
      long_flag_q <= long_flag_d;
      key_state_q <= key_state_d;
      press_q     <= press_d;
      short_q     <= short_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
    end
  end

  assign key_state  = key_state_q;
  assign key_press  = press_q;
  assign key_short  = short_q;
  assign key_long   = long_q;
  assign key_repeat = repeat_q;

endmodule

// File: rtl/key_event_detector.sv
// Four independent button filters feeding the clock's mode/set logic with
// debounced levels and classified press events instead of raw key lines.
module key_event_detector
  import key_pkg::*;
#(
  parameter int MCNT_DB   = 1_000_000,
  parameter int MCNT_LONG = 50_000_000,
  parameter int MCNT_RPT  = 10_000_000,
  parameter bit RPT_EN    = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Key,
  output logic [3:0] Key_state,
  output logic [3:0] Key_press,
  output logic [3:0] Key_short,
  output logic [3:0] Key_long,
  output logic [3:0] Key_repeat
);

  // One filter per key; no key has priority over another.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_filter #(
      .MCNT_DB  (MCNT_DB),
      .MCNT_LONG(MCNT_LONG),
      .MCNT_RPT (MCNT_RPT),
      .RPT_EN   (RPT_EN)
    ) u_filter (
      .clk       (Clk),
      .reset     (Reset),
      .key_n     (Key[i]),
      .key_state (Key_state[i]),
      .key_press (Key_press[i]),
      .key_short (Key_short[i]),
      .key_long  (Key_long[i]),
      .key_repeat(Key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_event_detector.sv
// Self-checking bench: two detectors (repeat enabled / disabled) share one
// Key bus and are compared every cycle against a run-length reference model.
module tb_key_event_detector;
  import key_pkg::*;

  localparam int DB = 4;
  localparam int LG = 20;
  localparam int RP = 5;

  logic       clk;
  logic       reset;
  logic [3:0] key;
  logic [3:0] a_state, a_press, a_short, a_long, a_rep;
  logic [3:0] b_state, b_press, b_short, b_long, b_rep;

  key_event_detector #(.MCNT_DB(DB), .MCNT_LONG(LG), .MCNT_RPT(RP), .RPT_EN(1'b1)) dut_a (
    .Clk(clk), .Reset(reset), .Key(key), .Key_state(a_state), .Key_press(a_press),
    .Key_short(a_short), .Key_long(a_long), .Key_repeat(a_rep));

  key_event_detector #(.MCNT_DB(DB), .MCNT_LONG(LG), .MCNT_RPT(RP), .RPT_EN(1'b0)) dut_b (
    .Clk(clk), .Reset(reset), .Key(key), .Key_state(b_state), .Key_press(b_press),
    .Key_short(b_short), .Key_long(b_long), .Key_repeat(b_rep));

  always #10 clk = ~clk;

  int checks;
  int errors;
  int cyc;

  // Reference model: synchroniser pipe, debounced level, run length of
  // samples disagreeing with that level, hold/repeat progress, long flag.
  logic [3:0] s1, s2;
  int held[4], run[4], hp[4], rp[4], lf[4];
  logic [3:0] e_state, e_press, e_short, e_long, e_rep;

  logic [19:0] got_a, got_b, exp_a, exp_b;
  assign got_a = {a_state, a_press, a_short, a_long, a_rep};
  assign got_b = {b_state, b_press, b_short, b_long, b_rep};
  assign exp_a = {e_state, e_press, e_short, e_long, e_rep};
  assign exp_b = {e_state, e_press, e_short, e_long, 4'b0000};

  // Drive one cycle of stimulus, advance the model at the edge, then settle.
  task automatic step(input logic [3:0] k, input logic r);
    logic ks;
    key   = k;
    reset = r;
    @(posedge clk);
    cyc++;
    e_press = 4'b0000;
    e_short = 4'b0000;
    e_long  = 4'b0000;
    e_rep   = 4'b0000;
    if (r) begin
      s1 = 4'hF;
      s2 = 4'hF;
    end
    for (int i = 0; i < 4; i++) begin
      if (r) begin
        held[i] = 0; run[i] = 0; hp[i] = 0; rp[i] = 0; lf[i] = 0;
      end else begin
        ks    = s2[i];
        s2[i] = s1[i];
        s1[i] = k[i];
        if (held[i] == 0) begin
          if (!ks) begin
            run[i]++;
            if (run[i] == DB + 1) begin
              held[i] = 1; run[i] = 0; hp[i] = 0; lf[i] = 0; e_press[i] = 1'b1;
            end
          end else begin
            run[i] = 0;
          end
        end else begin
          if (ks) begin
            run[i]++;
            if (run[i] == DB + 1) begin
              held[i] = 0; run[i] = 0;
              if (lf[i] == 0) e_short[i] = 1'b1;
            end
          end else if (run[i] > 0) begin
            run[i] = 0;
          end else if (lf[i] == 0) begin
            hp[i]++;
            if (hp[i] == LG) begin
              lf[i] = 1; rp[i] = 0; e_long[i] = 1'b1;
            end
          end else begin
            rp[i]++;
            if (rp[i] == RP) begin
              rp[i] = 0; e_rep[i] = 1'b1;
            end
          end
        end
      end
      e_state[i] = (held[i] != 0);
    end
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 5; c++) begin
      step(4'b0000, 1'b1);
      checks++;
      if (got_a !== 20'h00000 || got_b !== 20'h00000) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got_a=%h got_b=%h want=0", cyc, got_a, got_b);
      end
    end
    for (int c = 1; c <= 9; c++) begin
      step(4'b0000, 1'b0);
      checks++;
      if (got_a !== exp_a || got_b !== exp_b) begin
        errors++;
        $display("FAIL reset_release cyc=%0d got_a=%h exp_a=%h got_b=%h exp_b=%h", cyc, got_a, exp_a, got_b, exp_b);
      end
      checks++;
      if (c == 7) begin
        if (a_press !== 4'b1111 || a_state !== 4'b1111) begin
          errors++;
          $display("FAIL reset_press_latency press=%b state=%b want 1111/1111", a_press, a_state);
        end
      end else if (a_press !== 4'b0000) begin
        errors++;
        $display("FAIL reset_press_early c=%0d press=%b want 0000", c, a_press);
      end
    end
    for (int c = 0; c < 12; c++) begin
      step(4'b1111, 1'b0);
      checks++;
      if (got_a !== exp_a || got_b !== exp_b) begin
        errors++;
        $display("FAIL reset_drain cyc=%0d got_a=%h exp_a=%h got_b=%h exp_b=%h", cyc, got_a, exp_a, got_b, exp_b);
      end
    end
  endtask

  task automatic test_short();
    int np, ns, nl;
    logic [3:0] other;
    np = 0; ns = 0; nl = 0; other = 4'b0000;
    for (int c = 1; c <= 24; c++) begin
      step((c <= 12) ? 4'b0111 : 4'b1111, 1'b0);
      checks++;
      if (got_a !== exp_a || got_b !== exp_b) begin
        errors++;
        $display("FAIL short_model cyc=%0d got_a=%h exp_a=%h got_b=%h exp_b=%h", cyc, got_a, exp_a, got_b, exp_b);
      end
      np += int'(a_press[KEY_MODE]);
      ns += int'(a_short[KEY_MODE]);
      nl += int'(a_long[KEY_MODE]);
      other |= (a_press | a_short | a_long | a_rep | a_state) & 4'b0111;
      if (c == 7) begin
        checks++;
        if (a_press[KEY_MODE] !== 1'b1) begin
          errors++;
          $display("FAIL short_press_at7 got=%b want=1", a_press[KEY_MODE]);
        end
      end
      if (c == 19) begin
        checks++;
        if (a_short[KEY_MODE] !== 1'b1) begin
          errors++;
          $display("FAIL short_pulse_at_rise+7 got=%b want=1", a_short[KEY_MODE]);
        end
      end
    end
    checks++;
    if (np != 1 || ns != 1 || nl != 0 || other !== 4'b0000) begin
      errors++;
      $display("FAIL short_counts press=%0d short=%0d long=%0d other=%b want 1/1/0/0000", np, ns, nl, other);
    end
  endtask

  task automatic test_glitch();
    for (int c = 1; c <= 19; c++) begin
      step((c <= 3 || c == 6 || c == 7) ? 4'b1011 : 4'b1111, 1'b0);
      checks++;
      if (got_a !== exp_a || got_b !== exp_b) begin
        errors++;
        $display("FAIL glitch_model cyc=%0d got_a=%h exp_a=%h got_b=%h exp_b=%h", cyc, got_a, exp_a, got_b, exp_b);
      end
      checks++;
      if (a_state[KEY_UP] !== 1'b0 || (a_press | a_short | a_long | a_rep) !== 4'b0000) begin
        errors++;
        $display("FAIL glitch_quiet c=%0d state=%b pulses=%b want 0/0000", c, a_state, a_press | a_short | a_long | a_rep);
      end
    end
  endtask

  task automatic test_long();
    int np, nl, ns, nra, nrb;
    np = 0; nl = 0; ns = 0; nra = 0; nrb = 0;
    for (int c = 1; c <= 75; c++) begin
      step((c <= 60) ? 4'b1011 : 4'b1111, 1'b0);
      checks++;
      if (got_a !== exp_a || got_b !== exp_b) begin
        errors++;
        $display("FAIL long_model cyc=%0d got_a=%h exp_a=%h got_b=%h exp_b=%h", cyc, got_a, exp_a, got_b, exp_b);
      end
      np  += int'(a_press[KEY_UP]);
      nl  += int'(a_long[KEY_UP]);
      ns  += int'(a_short[KEY_UP]);
      nra += int'(a_rep[KEY_UP]);
      nrb += int'(b_rep[KEY_UP]);
      if (c == 27) begin
        checks++;
        if (a_long[KEY_UP] !== 1'b1 || b_long[KEY_UP] !== 1'b1) begin
          errors++;
          $display("FAIL long_at_press+20 a=%b b=%b want 1/1", a_long[KEY_UP], b_long[KEY_UP]);
        end
      end
    end
    checks++;
    if (np != 1 || nl != 1 || ns != 0 || nra != 7 || nrb != 0) begin
      errors++;
      $display("FAIL long_counts press=%0d long=%0d short=%0d repA=%0d repB=%0d want 1/1/0/7/0", np, nl, ns, nra, nrb);
    end
  endtask

  task automatic test_glitch_long();
    int np, nl, ns;
    logic dropped;
    np = 0; nl = 0; ns = 0; dropped = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      step((c <= 40 || (c >= 43 && c <= 62)) ? 4'b1101 : 4'b1111, 1'b0);
      checks++;
      if (got_a !== exp_a || got_b !== exp_b) begin
        errors++;
        $display("FAIL glong_model cyc=%0d got_a=%h exp_a=%h got_b=%h exp_b=%h", cyc, got_a, exp_a, got_b, exp_b);
      end
      np += int'(a_press[KEY_DN]);
      nl += int'(a_long[KEY_DN]);
      ns += int'(a_short[KEY_DN]);
      if (c >= 8 && c <= 62 && a_state[KEY_DN] !== 1'b1) dropped = 1'b1;
    end
    checks++;
    if (np != 1 || nl != 1 || ns != 0 || dropped) begin
      errors++;
      $display("FAIL glong_counts press=%0d long=%0d short=%0d dropped=%b want 1/1/0/0", np, nl, ns, dropped);
    end
  endtask

  task automatic test_back_to_back();
    int ns;
    ns = 0;
    for (int c = 1; c <= 24; c++) begin
      step((c <= 12) ? 4'b0111 : 4'b1110, 1'b0);
      checks++;
      if (got_a !== exp_a || got_b !== exp_b) begin
        errors++;
        $display("FAIL b2b_model cyc=%0d got_a=%h exp_a=%h got_b=%h exp_b=%h", cyc, got_a, exp_a, got_b, exp_b);
      end
      if (c == 19) begin
        checks++;
        if (a_press[KEY_OK] !== 1'b1 || a_short[KEY_MODE] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_same_cycle press0=%b short3=%b want 1/1", a_press[KEY_OK], a_short[KEY_MODE]);
        end
      end
    end
    step(4'b1110, 1'b1);
    checks++;
    if (got_a !== 20'h00000 || got_b !== 20'h00000) begin
      errors++;
      $display("FAIL mid_down_reset got_a=%h got_b=%h want=0", got_a, got_b);
    end
    for (int c = 0; c < 15; c++) begin
      step(4'b1111, 1'b0);
      checks++;
      if (got_a !== exp_a || got_b !== exp_b) begin
        errors++;
        $display("FAIL post_reset_model cyc=%0d got_a=%h exp_a=%h got_b=%h exp_b=%h", cyc, got_a, exp_a, got_b, exp_b);
      end
      ns += int'(a_short[KEY_OK]);
    end
    checks++;
    if (ns != 0) begin
      errors++;
      $display("FAIL post_reset_short count=%0d want 0", ns);
    end
  endtask

  task automatic test_random();
    int dur[4];
    logic [3:0] lvl;
    logic r;
    lvl = 4'hF;
    for (int i = 0; i < 4; i++) dur[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (dur[i] == 0) begin
          lvl[i] = 1'($urandom_range(0, 1));
          dur[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 45));
        end
        dur[i]--;
      end
      r = ($urandom_range(0, 599) == 0);
      step(lvl, r);
      checks++;
      if (got_a !== exp_a || got_b !== exp_b) begin
        errors++;
        $display("FAIL random_model cyc=%0d got_a=%h exp_a=%h got_b=%h exp_b=%h", cyc, got_a, exp_a, got_b, exp_b);
      end
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; key = 4'hF;
    checks = 0; errors = 0; cyc = 0;
    s1 = 4'hF; s2 = 4'hF;
    e_state = 4'b0000; e_press = 4'b0000; e_short = 4'b0000; e_long = 4'b0000; e_rep = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      held[i] = 0; run[i] = 0; hp[i] = 0; rp[i] = 0; lf[i] = 0;
    end
    test_reset();
    test_short();
    test_glitch();
    test_long();
    test_glitch_long();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
